// File: rtl/axi_lite_vram_filler_if.sv
// AXI4-Lite bus bundle between the VRAM filler (master) and the text
// controller register/VRAM slave port.
interface axi_lite_vram_filler_if #(
  parameter int C_AXI_DATA_WIDTH = 32,
  parameter int C_AXI_ADDR_WIDTH = 16
);
  logic [C_AXI_ADDR_WIDTH-1:0]   awaddr;
  logic [2:0]                    awprot;
  logic                          awvalid;
  logic                          awready;
  logic [C_AXI_DATA_WIDTH-1:0]   wdata;
  logic [C_AXI_DATA_WIDTH/8-1:0] wstrb;
  logic                          wvalid;
  logic                          wready;
  logic [1:0]                    bresp;
  logic                          bvalid;
  logic                          bready;
  logic [C_AXI_ADDR_WIDTH-1:0]   araddr;
  logic [2:0]                    arprot;
  logic                          arvalid;
  logic                          arready;
  logic [C_AXI_DATA_WIDTH-1:0]   rdata;
  logic [1:0]                    rresp;
  logic                          rvalid;
  logic                          rready;

  modport master (
    output awaddr, awprot, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input bresp, bvalid, output bready,
    output araddr, arprot, arvalid, input arready,
    input rdata, rresp, rvalid, output rready
  );

  modport slave (
    input awaddr, awprot, awvalid, output awready,
    input wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready,
    input araddr, arprot, arvalid, output arready,
    output rdata, rresp, rvalid, input rready
  );
endinterface

// File: rtl/axi_lite_vram_filler.sv
// AXI4-Lite master that fills a word range with an arithmetic pattern
// (value + i*incr) using single-beat writes, then optionally reads every
// word back and counts mismatches. One transaction outstanding at a time.
module axi_lite_vram_filler #(
  parameter int C_AXI_DATA_WIDTH = 32,
  parameter int C_AXI_ADDR_WIDTH = 16,
  parameter int CNT_WIDTH        = 12
) (
  input  logic                        axi_aclk,
  input  logic                        axi_aresetn,
  input  logic                        start,
  input  logic [C_AXI_ADDR_WIDTH-1:0] base_addr,
  input  logic [CNT_WIDTH-1:0]        word_count,
  input  logic [C_AXI_DATA_WIDTH-1:0] fill_value,
  input  logic [C_AXI_DATA_WIDTH-1:0] fill_incr,
  input  logic                        verify,
  output logic                        busy,
  output logic                        done,
  output logic                        resp_err,
  output logic [CNT_WIDTH-1:0]        mismatch_cnt,
  output logic [C_AXI_ADDR_WIDTH-1:0] first_err_addr,
  axi_lite_vram_filler_if.master      m_axi
);

  localparam logic [C_AXI_ADDR_WIDTH-1:0] ADDR_STEP = C_AXI_ADDR_WIDTH'(4);
  localparam logic [C_AXI_ADDR_WIDTH-1:0] ADDR_MASK = ~C_AXI_ADDR_WIDTH'(3);
  localparam logic [CNT_WIDTH-1:0]        CNT_ONE   = CNT_WIDTH'(1);
  localparam logic [1:0]                  RESP_OKAY = 2'b00;

  typedef enum logic [2:0] {
    S_IDLE, S_W_ADDR, S_W_RESP, S_R_ADDR, S_R_DATA, S_FINISH
  } state_t;

  state_t                      state_q, state_d;
  logic [C_AXI_ADDR_WIDTH-1:0] base_q, base_d;
  logic [CNT_WIDTH-1:0]        cnt_q, cnt_d;
  logic [C_AXI_DATA_WIDTH-1:0] fill_q, fill_d;
  logic [C_AXI_DATA_WIDTH-1:0] incr_q, incr_d;
  logic                        verify_q, verify_d;
  logic [CNT_WIDTH-1:0]        idx_q, idx_d;
  logic [C_AXI_DATA_WIDTH-1:0] acc_q, acc_d;
  logic [C_AXI_ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
  logic [C_AXI_DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [C_AXI_ADDR_WIDTH-1:0] araddr_q, araddr_d;
  logic                        awvalid_q, awvalid_d;
  logic                        wvalid_q, wvalid_d;
  logic                        bready_q, bready_d;
  logic                        arvalid_q, arvalid_d;
  logic                        rready_q, rready_d;
  logic                        busy_q, busy_d;
  logic                        done_q, done_d;
  logic                        resp_err_q, resp_err_d;
  logic [CNT_WIDTH-1:0]        mis_q, mis_d;
  logic [C_AXI_ADDR_WIDTH-1:0] first_err_q, first_err_d;

  logic aw_fire, w_fire, ar_fire, last_word;
  logic [C_AXI_DATA_WIDTH-1:0] acc_next;

  assign aw_fire   = awvalid_q & m_axi.awready;
  assign w_fire    = wvalid_q & m_axi.wready;
  assign ar_fire   = arvalid_q & m_axi.arready;
  assign last_word = (idx_q == cnt_q - CNT_ONE);
  assign acc_next  = acc_q + incr_q;

  // Next-state and next-output computation for the fill/verify sequencer.
  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    cnt_d       = cnt_q;
    fill_d      = fill_q;
    incr_d      = incr_q;
    verify_d    = verify_q;
    idx_d       = idx_q;
    acc_d       = acc_q;
    awaddr_d    = awaddr_q;
    wdata_d     = wdata_q;
    araddr_d    = araddr_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    bready_d    = bready_q;
    arvalid_d   = arvalid_q;
    rready_d    = rready_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    resp_err_d  = resp_err_q;
    mis_d       = mis_q;
    first_err_d = first_err_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          base_d     = base_addr & ADDR_MASK;
          cnt_d      = word_count;
          fill_d     = fill_value;
          incr_d     = fill_incr;
          verify_d   = verify;
          idx_d      = '0;
          acc_d      = fill_value;
          resp_err_d = 1'b0;
          mis_d      = '0;
          if (word_count == '0) begin
            // Nothing to transfer: report completion without touching the bus.
            state_d = S_FINISH;
            done_d  = 1'b1;
          end else begin
            state_d   = S_W_ADDR;
            busy_d    = 1'b1;
            awaddr_d  = base_addr & ADDR_MASK;
            wdata_d   = fill_value;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
          end
        end
      end

      S_W_ADDR: begin
        // AW and W complete independently; a dropped valid means its
        // handshake has already happened.
        if (aw_fire) awvalid_d = 1'b0;
        if (w_fire)  wvalid_d  = 1'b0;
        if ((aw_fire || !awvalid_q) && (w_fire || !wvalid_q)) begin
          state_d  = S_W_RESP;
          bready_d = 1'b1;
        end
      end

      S_W_RESP: begin
        if (m_axi.bvalid) begin
          bready_d = 1'b0;
          if (m_axi.bresp != RESP_OKAY) resp_err_d = 1'b1;
          if (!last_word) begin
            state_d   = S_W_ADDR;
            idx_d     = idx_q + CNT_ONE;
            acc_d     = acc_next;
            awaddr_d  = awaddr_q + ADDR_STEP;
            wdata_d   = acc_next;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
          end else if (verify_q) begin
            state_d   = S_R_ADDR;
            idx_d     = '0;
            acc_d     = fill_q;
            araddr_d  = base_q;
            arvalid_d = 1'b1;
          end else begin
            state_d = S_FINISH;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end
      end

      S_R_ADDR: begin
        if (ar_fire) begin
          state_d   = S_R_DATA;
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
        end
      end

      S_R_DATA: begin
        if (m_axi.rvalid) begin
          rready_d = 1'b0;
          if (m_axi.rdata != acc_q) begin
            if (mis_q != '1) mis_d = mis_q + CNT_ONE;
            if (mis_q == '0) first_err_d = araddr_q;
          end
          if (m_axi.rresp != RESP_OKAY) resp_err_d = 1'b1;
          if (!last_word) begin
            state_d   = S_R_ADDR;
            idx_d     = idx_q + CNT_ONE;
            acc_d     = acc_next;
            araddr_d  = araddr_q + ADDR_STEP;
            arvalid_d = 1'b1;
          end else begin
            state_d = S_FINISH;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end
      end

      S_FINISH: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase
  end

  // State and registered outputs; reset abandons any transaction at once.
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      state_q     <= S_IDLE;
      base_q      <= '0;
      cnt_q       <= '0;
      fill_q      <= '0;
      incr_q      <= '0;
      verify_q    <= 1'b0;
      idx_q       <= '0;
      acc_q       <= '0;
      awaddr_q    <= '0;
      wdata_q     <= '0;
      araddr_q    <= '0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      resp_err_q  <= 1'b0;
      mis_q       <= '0;
      first_err_q <= '0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      cnt_q       <= cnt_d;
      fill_q      <= fill_d;
      incr_q      <= incr_d;
      verify_q    <= verify_d;
      idx_q       <= idx_d;
      acc_q       <= acc_d;
      awaddr_q    <= awaddr_d;
      wdata_q     <= wdata_d;
      araddr_q    <= araddr_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      bready_q    <= bready_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      resp_err_q  <= resp_err_d;
      mis_q       <= mis_d;
      first_err_q <= first_err_d;
    end
  end

  assign m_axi.awaddr  = awaddr_q;
  assign m_axi.awprot  = 3'b000;
  assign m_axi.awvalid = awvalid_q;
  assign m_axi.wdata   = wdata_q;
  assign m_axi.wstrb   = '1;
  assign m_axi.wvalid  = wvalid_q;
  assign m_axi.bready  = bready_q;
  assign m_axi.araddr  = araddr_q;
  assign m_axi.arprot  = 3'b000;
  assign m_axi.arvalid = arvalid_q;
  assign m_axi.rready  = rready_q;

  assign busy           = busy_q;
  assign done           = done_q;
  assign resp_err       = resp_err_q;
  assign mismatch_cnt   = mis_q;
  assign first_err_addr = first_err_q;

endmodule

// File: tb/tb_axi_lite_vram_filler.sv
// Bench for axi_lite_vram_filler: a behavioural AXI4-Lite memory slave with
// programmable ready delays, error injection and readback corruption, plus a
// scoreboard of expected write/read addresses and write data.
module tb_axi_lite_vram_filler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] base_addr;
  logic [11:0] word_count;
  logic [31:0] fill_value;
  logic [31:0] fill_incr;
  logic        verify;
  logic        busy, done, resp_err;
  logic [11:0] mismatch_cnt;
  logic [15:0] first_err_addr;

  always #5 clk = ~clk;

  axi_lite_vram_filler_if #(.C_AXI_DATA_WIDTH(32), .C_AXI_ADDR_WIDTH(16)) bus ();

  axi_lite_vram_filler #(
    .C_AXI_DATA_WIDTH(32), .C_AXI_ADDR_WIDTH(16), .CNT_WIDTH(12)
  ) dut (
    .axi_aclk       (clk),
    .axi_aresetn    (rst_n),
    .start          (start),
    .base_addr      (base_addr),
    .word_count     (word_count),
    .fill_value     (fill_value),
    .fill_incr      (fill_incr),
    .verify         (verify),
    .busy           (busy),
    .done           (done),
    .resp_err       (resp_err),
    .mismatch_cnt   (mismatch_cnt),
    .first_err_addr (first_err_addr),
    .m_axi          (bus)
  );

  // ---------------- slave model ----------------
  int          aw_dly = 0, w_dly = 0;
  logic        err_en = 1'b0, bad_en = 1'b0;
  logic [15:0] err_addr = '0, bad_addr = '0;
  int          aw_cnt, w_cnt;
  logic        aw_got, w_got;
  logic [15:0] aw_addr_l;
  logic [31:0] wd_l;
  logic [31:0] mem [0:16383];

  assign bus.awready = bus.awvalid && (aw_cnt >= aw_dly);
  assign bus.wready  = bus.wvalid && (w_cnt >= w_dly);
  assign bus.arready = bus.arvalid;

  always @(posedge clk or negedge rst_n) begin : slave
    logic        a_fire, d_fire, a_ok, d_ok;
    logic [15:0] addr_v;
    logic [31:0] data_v;
    if (!rst_n) begin
      aw_cnt <= 0; w_cnt <= 0; aw_got <= 1'b0; w_got <= 1'b0;
      aw_addr_l <= '0; wd_l <= '0;
      bus.bvalid <= 1'b0; bus.bresp <= 2'b00;
      bus.rvalid <= 1'b0; bus.rdata <= '0; bus.rresp <= 2'b00;
    end else begin
      a_fire = bus.awvalid && bus.awready;
      d_fire = bus.wvalid && bus.wready;
      if (a_fire) aw_cnt <= 0; else if (bus.awvalid) aw_cnt <= aw_cnt + 1;
      if (d_fire) w_cnt <= 0;  else if (bus.wvalid)  w_cnt <= w_cnt + 1;
      a_ok   = aw_got || a_fire;
      d_ok   = w_got || d_fire;
      addr_v = a_fire ? bus.awaddr : aw_addr_l;
      data_v = d_fire ? bus.wdata : wd_l;
      if (a_fire) aw_addr_l <= bus.awaddr;
      if (d_fire) wd_l <= bus.wdata;
      if (bus.bvalid && bus.bready) bus.bvalid <= 1'b0;
      if (a_ok && d_ok) begin
        mem[addr_v[15:2]] <= data_v;
        bus.bvalid <= 1'b1;
        bus.bresp  <= (err_en && addr_v == err_addr) ? 2'b10 : 2'b00;
        aw_got <= 1'b0;
        w_got  <= 1'b0;
      end else begin
        if (a_fire) aw_got <= 1'b1;
        if (d_fire) w_got  <= 1'b1;
      end
      if (bus.arvalid && bus.arready) begin
        bus.rvalid <= 1'b1;
        bus.rdata  <= mem[bus.araddr[15:2]] ^
                      ((bad_en && bus.araddr == bad_addr) ? 32'h0000_0100 : 32'h0);
        bus.rresp  <= 2'b00;
      end else if (bus.rvalid && bus.rready) begin
        bus.rvalid <= 1'b0;
      end
    end
  end

  // ---------------- checking and scoreboard ----------------
  int n_vec = 0, n_miss = 0;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  logic [15:0] exp_aw[$];
  logic [31:0] exp_w[$];
  logic [15:0] exp_ar[$];
  int   n_aw = 0, n_w = 0, n_ar = 0, n_b = 0;
  logic saw_valid = 1'b0;
  logic p_aw_hs = 1'b0, p_w_hs = 1'b0, p_ar_hs = 1'b0;
  logic p_aw_wait = 1'b0, p_w_wait = 1'b0;
  logic [15:0] p_awaddr = '0;
  logic [31:0] p_wdata = '0;

  // Called once per falling edge while a run is in progress.
  task automatic sample_bus();
    logic aw_hs, w_hs, ar_hs;
    aw_hs = bus.awvalid && bus.awready;
    w_hs  = bus.wvalid && bus.wready;
    ar_hs = bus.arvalid && bus.arready;
    if (p_aw_hs) check_eq("awvalid_drop", bus.awvalid, 0);
    if (p_w_hs)  check_eq("wvalid_drop", bus.wvalid, 0);
    if (p_ar_hs) check_eq("arvalid_drop", bus.arvalid, 0);
    if (p_aw_wait) begin
      check_eq("awvalid_hold", bus.awvalid, 1);
      check_eq("awaddr_stable", bus.awaddr, p_awaddr);
    end
    if (p_w_wait) begin
      check_eq("wvalid_hold", bus.wvalid, 1);
      check_eq("wdata_stable", bus.wdata, p_wdata);
    end
    if (aw_hs) begin
      n_aw++;
      check_eq("aw_expected", exp_aw.size() > 0, 1);
      if (exp_aw.size() > 0) check_eq("awaddr", bus.awaddr, exp_aw.pop_front());
      check_eq("awprot", bus.awprot, 0);
    end
    if (w_hs) begin
      n_w++;
      check_eq("w_expected", exp_w.size() > 0, 1);
      if (exp_w.size() > 0) check_eq("wdata", bus.wdata, exp_w.pop_front());
      check_eq("wstrb", bus.wstrb, 4'hF);
    end
    if (ar_hs) begin
      n_ar++;
      check_eq("ar_expected", exp_ar.size() > 0, 1);
      if (exp_ar.size() > 0) check_eq("araddr", bus.araddr, exp_ar.pop_front());
    end
    if (bus.bvalid && bus.bready) n_b++;
    if (bus.awvalid || bus.wvalid || bus.arvalid) saw_valid = 1'b1;
    p_aw_hs   = aw_hs;
    p_w_hs    = w_hs;
    p_ar_hs   = ar_hs;
    p_aw_wait = bus.awvalid && !bus.awready;
    p_w_wait  = bus.wvalid && !bus.wready;
    p_awaddr  = bus.awaddr;
    p_wdata   = bus.wdata;
  endtask

  task automatic clear_monitor();
    exp_aw.delete(); exp_w.delete(); exp_ar.delete();
    p_aw_hs = 0; p_w_hs = 0; p_ar_hs = 0; p_aw_wait = 0; p_w_wait = 0;
    saw_valid = 1'b0;
  endtask

  // Drive one fill request, score it, and return the start-to-done latency
  // in clock edges.
  task automatic run_fill(input logic [15:0] b, input int cnt, input logic [31:0] v,
                          input logic [31:0] inc, input logic vf, input logic mid_start,
                          output int lat);
    int aw0, ar0, b0, k;
    logic [15:0] a;
    aw0 = n_aw; ar0 = n_ar; b0 = n_b;
    saw_valid = 1'b0;
    for (int i = 0; i < cnt; i++) begin
      a = (b & 16'hFFFC) + 16'(4 * i);
      exp_aw.push_back(a);
      exp_w.push_back(v + 32'(i) * inc);
      if (vf) exp_ar.push_back(a);
    end
    @(negedge clk);
    base_addr = b; word_count = 12'(cnt); fill_value = v; fill_incr = inc; verify = vf;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    // Later input changes must have no effect on the run in progress.
    base_addr = ~b; word_count = 12'(cnt + 3); fill_value = ~v; fill_incr = ~inc; verify = ~vf;
    k = 0;
    forever begin
      sample_bus();
      if (done) break;
      if (k >= 2000) begin
        check_eq("done_timeout", k, 0);
        break;
      end
      @(negedge clk);
      k++;
      if (mid_start && k == 3) start = 1'b1;
      if (mid_start && k == 4) start = 1'b0;
    end
    lat = k + 1;
    check_eq("busy_at_done", busy, 0);
    @(negedge clk);
    sample_bus();
    check_eq("done_one_cycle", done, 0);
    if (mid_start) begin
      for (int j = 0; j < 6; j++) begin
        @(negedge clk);
        sample_bus();
        check_eq("no_second_done", done, 0);
        check_eq("no_second_busy", busy, 0);
      end
    end
    check_eq("aw_count", n_aw - aw0, cnt);
    check_eq("ar_count", n_ar - ar0, vf ? cnt : 0);
    check_eq("b_count", n_b - b0, cnt);
    check_eq("aw_left", exp_aw.size(), 0);
    check_eq("w_left", exp_w.size(), 0);
    check_eq("ar_left", exp_ar.size(), 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int lat;
    rst_n = 1'b0; start = 1'b0; base_addr = '0; word_count = '0;
    fill_value = '0; fill_incr = '0; verify = 1'b0;
    repeat (3) @(negedge clk);

    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_resp_err", resp_err, 0);
    check_eq("rst_mismatch", mismatch_cnt, 0);
    check_eq("rst_first_err", first_err_addr, 0);
    check_eq("rst_awvalid", bus.awvalid, 0);
    check_eq("rst_wvalid", bus.wvalid, 0);
    check_eq("rst_arvalid", bus.arvalid, 0);
    check_eq("rst_bready", bus.bready, 0);
    check_eq("rst_rready", bus.rready, 0);
    check_eq("rst_awaddr", bus.awaddr, 0);
    check_eq("rst_araddr", bus.araddr, 0);
    check_eq("rst_wdata", bus.wdata, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Plain write-only fill, zero-wait slave.
    run_fill(16'h0000, 4, 32'h11, 32'h0101_0101, 1'b0, 1'b0, lat);
    check_eq("fill_latency", lat, 9);
    check_eq("fill_resp_err", resp_err, 0);
    check_eq("mem_word3", mem[3], 32'h0303_0314);

    // Skewed handshakes: AW late, then W late.
    aw_dly = 3; w_dly = 0;
    run_fill(16'h0100, 3, 32'hA000_0000, 32'h10, 1'b0, 1'b0, lat);
    aw_dly = 0; w_dly = 3;
    run_fill(16'h0200, 3, 32'hB000_0001, 32'hFFFF_FFFF, 1'b0, 1'b0, lat);
    w_dly = 0;

    // Verify with readback corruption on word 5.
    bad_en = 1'b1; bad_addr = 16'h0014;
    run_fill(16'h0000, 8, 32'h1234_5678, 32'h0000_0003, 1'b1, 1'b0, lat);
    check_eq("verify_mismatch", mismatch_cnt, 1);
    check_eq("verify_first_err", first_err_addr, 16'h0014);
    check_eq("verify_resp_err", resp_err, 0);
    bad_en = 1'b0;

    // Clean verify: no mismatch expected and the counter was cleared on start.
    run_fill(16'h0400, 5, 32'hDEAD_0000, 32'h0001_0001, 1'b1, 1'b0, lat);
    check_eq("clean_mismatch", mismatch_cnt, 0);
    check_eq("clean_latency", lat, 5 * 2 + 5 * 2 + 1);

    // Error response on word 2, the fill still completes.
    err_en = 1'b1; err_addr = 16'h0308;
    run_fill(16'h0300, 4, 32'h0, 32'h1, 1'b0, 1'b0, lat);
    check_eq("bresp_err", resp_err, 1);
    err_en = 1'b0;

    // Zero count: error cleared, immediate done, no bus activity.
    run_fill(16'h0500, 0, 32'h5, 32'h5, 1'b1, 1'b0, lat);
    check_eq("zero_latency", lat, 1);
    check_eq("zero_resp_err", resp_err, 0);
    check_eq("zero_no_valid", saw_valid, 0);

    // Address wrap with a start pulsed mid-run.
    run_fill(16'hFFF8, 4, 32'h7, 32'h9, 1'b0, 1'b1, lat);
    check_eq("wrap_latency", lat, 9);

    // Reset asserted while a write address is pending.
    aw_dly = 50;
    clear_monitor();
    @(negedge clk);
    base_addr = 16'h0600; word_count = 12'd4; fill_value = 32'h1; fill_incr = 32'h1;
    verify = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_eq("pre_rst_awvalid", bus.awvalid, 1);
    check_eq("pre_rst_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("async_awvalid", bus.awvalid, 0);
    check_eq("async_wvalid", bus.wvalid, 0);
    check_eq("async_busy", busy, 0);
    aw_dly = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("post_rst_busy", busy, 0);
    check_eq("post_rst_awvalid", bus.awvalid, 0);
    run_fill(16'h0700, 3, 32'hCAFE_0000, 32'h100, 1'b1, 1'b0, lat);
    check_eq("post_rst_latency", lat, 3 * 2 + 3 * 2 + 1);
    check_eq("post_rst_mismatch", mismatch_cnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/axi_lite_vram_filler.md
# axi_lite_vram_filler

AXI4-Lite master that bulk-initialises the text controller's VRAM and palette registers without processor involvement. It sits directly upstream of the HDMI text controller's AXI4-Lite slave port and issues one single-beat write per word from an arithmetic pattern. It optionally reads every word back and compares it against the expected value. Used for power-on screen clear, palette load, and self-test of the controller's register file.

## Interface
- C_AXI_DATA_WIDTH, 32: AXI data width; only 32 supported.
- C_AXI_ADDR_WIDTH, 16: AXI address width; byte addresses.
- CNT_WIDTH, 12: width of word_count and the internal word index.

Ports:
- axi_aclk  in  1  single clock for all logic.
- axi_aresetn  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request; sampled only while IDLE.
- base_addr  in  C_AXI_ADDR_WIDTH  byte address of word 0; bits [1:0] ignored (treated as 0).
- word_count  in  CNT_WIDTH  number of words to write.
- fill_value  in  32  data for word 0.
- fill_incr  in  32  added per word.
- verify  in  1  enables the readback phase.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse at completion.
- resp_err  out  1  sticky; any BRESP/RRESP ≠ OKAY; cleared on the next accepted start.
- mismatch_cnt  out  CNT_WIDTH  readback mismatches, saturating; cleared on start.
- first_err_addr  out  C_AXI_ADDR_WIDTH  byte address of the first mismatch.
- m_axi_awaddr/awprot/awvalid/awready, m_axi_wdata/wstrb/wvalid/wready, m_axi_bresp/bvalid/bready, m_axi_araddr/arprot/arvalid/arready, m_axi_rdata/rresp/rvalid/rready: standard AXI4-Lite master. awprot = arprot = 0. wstrb = 4'hF.

## Operation
- Words are indexed i = 0..word_count-1.
  - Address = base_addr + 4·i, truncated to C_AXI_ADDR_WIDTH (wraps).
  - Data = fill_value + i·fill_incr, mod 2^32; computed by running accumulation, no multiplier.
- All command inputs are latched on an accepted start. Later changes have no effect.
- State machine:
  - IDLE: start=1 → W_ADDR. If word_count=0, go to FINISH instead; no bus traffic.
  - W_ADDR: awvalid and wvalid asserted together.
    - Each valid drops independently in the cycle after its own handshake (valid&ready at a rising edge).
    - When both handshakes are complete → W_RESP.
  - W_RESP: bready=1. On bvalid, record the error if bresp≠0.
    - If more words remain: advance i, accumulate data, → W_ADDR.
    - Else: → R_ADDR if verify, otherwise FINISH.
  - R_ADDR: i restarts at 0 and the data accumulator restarts at fill_value. arvalid=1 until arready → R_DATA.
  - R_DATA: rready=1. On rvalid, compare rdata with the expected value.
    - On mismatch: increment mismatch_cnt (saturating at all-ones). Capture first_err_addr only when mismatch_cnt was 0.
    - Record the error if rresp≠0.
    - Then advance → R_ADDR, or → FINISH after the last word.
  - FINISH: done=1 for exactly one cycle, busy=0 → IDLE.
- At most one outstanding transaction; writes and reads never overlap.
- A start asserted while busy is ignored and not queued.

## Timing
- Reset values:
  - All valid/ready outputs, busy, done, resp_err: 0.
  - mismatch_cnt, first_err_addr, address outputs, wdata: 0.
  - State: IDLE.
- Reset asserted mid-transaction: all outputs return to reset values immediately (asynchronous); the transaction is abandoned.
- Start accepted at edge N → busy=1 and awvalid=wvalid=1 from edge N+1.
- Zero-wait slave, one write: AW/W handshake at N+1, bvalid at N+2, done at N+3. Best case is 2 cycles per write and 2 per read.
- Valids are never withdrawn before their handshake. Address and data stay stable while valid is high.
- bready is high only in W_RESP; rready is high only in R_DATA.
- done and a new start may share an edge; that start is ignored (the FSM is not IDLE).

## Test plan
- Write-only fill: base=0x0000, count=4, value=0x11, incr=0x01010101, verify=0, zero-wait slave.
  - Required: awaddr 0,4,8,0xC with wdata 0x11, 0x01010112, 0x02020213, 0x03030314.
  - done 9 cycles after the start edge; resp_err=0.
- Skewed handshakes: slave delays awready by 3 cycles and wready by 0 (then the reverse).
  - Required: each valid drops one cycle after its own handshake; exactly one write per word; no duplicates.
- Verify with a fault: count=8, verify=1, slave memory corrupts word 5 on readback.
  - Required: mismatch_cnt=1, first_err_addr=0x14, 8 reads issued after the 8 writes.
- Error response and zero count:
  - Slave returns bresp=2'b10 on word 2 → resp_err=1 and the fill still completes all words.
  - Next start with count=0 → resp_err cleared, done exactly one cycle after start, no valid asserted.
- Address wrap and start-while-busy: base=0xFFF8, count=4.
  - Required: awaddr 0xFFF8, 0xFFFC, 0x0000, 0x0004.
  - A second start pulsed mid-run is ignored; exactly one done pulse.
- Reset mid-write: drop axi_aresetn while awvalid=1.
  - Required: awvalid, wvalid and busy go low without waiting for a clock edge.
  - After release, the FSM is IDLE and a fresh start runs normally.
